bsg_upstream_out_mc: RTL and testbench

Parametrised multi-channel upstream output serializer for the off-chip link, running entirely in the io clock domain. It accepts one core word per handshake and slices it into per-channel beats. Each beat is emitted as two phases, even then odd, and each phase drives one PHY_W-bit lane per channel. Sending is gated by per-channel credit counters, which are replenished by toggle-encoded tokens returned from the receiver. This generalises the fixed 2-channel, 64-bit, 8-bit-lane output path in channel count, lane width, word width and credit depth. It adds explicit stall, commit, credit-overflow and token-rate behaviour.

---
 rtl/bsg_upstream_out_mc_pkg.sv | 33 +++
 rtl/bsg_upstream_credit_ctr.sv | 56 +++++
 rtl/bsg_upstream_out_mc.sv | 150 +++++++++++++++
 tb/tb_bsg_upstream_out_mc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_upstream_out_mc_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel upstream output serializer.
// Derived widths live here so the top module and the credit counter agree on them.
package bsg_upstream_out_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } uo_state_e;

  function automatic int beat_w_f(input int phy_w);
    return 2 * phy_w;
  endfunction

  function automatic int beats_f(input int word_w, input int channels, input int phy_w);
    return word_w / (channels * 2 * phy_w);
  endfunction

  function automatic int cnt_w_f(input int credits);
    return $clog2(credits + 1);
  endfunction

  function automatic bit is_pow2_f(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// Elaboration-time legality guard; expands to a generate block that only exists on a bad setting.
`define BSG_UOMC_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("bsg_upstream_out_mc: illegal parameter combination"); \
  end

// File: rtl/bsg_upstream_credit_ctr.sv
// Per-channel credit counter: toggle-token edge detect, saturating add/decrement, sticky overflow.
// has_credit also counts a token arriving this cycle so a stalled link restarts one cycle later.
module bsg_upstream_credit_ctr
  import bsg_upstream_out_mc_pkg::*;
#(
  parameter int CREDITS     = 32,
  parameter int TOKEN_RATIO = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          token,
  input  logic                          dec,
  output logic [cnt_w_f(CREDITS)-1:0]   credit,
  output logic                          has_credit,
  output logic                          overflow
);

  localparam int CNT_W  = cnt_w_f(CREDITS);
  localparam int CNT_W1 = CNT_W + 1;
  localparam logic [CNT_W:0] MAX_V   = CNT_W1'(CREDITS);
  localparam logic [CNT_W:0] RATIO_V = CNT_W1'(TOKEN_RATIO);
  localparam logic [CNT_W:0] ONE_V   = CNT_W1'(1);

  logic             token_q;
  logic             toggle;
  logic             take;
  logic [CNT_W-1:0] credit_q;
  logic [CNT_W:0]   sum;

  assign toggle = token ^ token_q;
  assign take   = dec && (credit_q != '0);

  // One extra bit so credit + ratio can be compared against the ceiling.
  always_comb begin
    sum = {1'b0, credit_q};
    if (toggle) sum = sum + RATIO_V;
    if (take)   sum = sum - ONE_V;
  end

  always_ff @(posedge clk) begin
    token_q <= token;
    if (rst) begin
      credit_q <= MAX_V[CNT_W-1:0];
      overflow <= 1'b0;
    end else if (sum > MAX_V) begin
      credit_q <= MAX_V[CNT_W-1:0];
      overflow <= 1'b1;
    end else begin
      credit_q <= sum[CNT_W-1:0];
    end
  end

  assign credit     = credit_q;
  assign has_credit = (credit_q != '0) || toggle;

endmodule

// File: rtl/bsg_upstream_out_mc.sv
// Multi-channel upstream output serializer: slices a core word into per-channel beats,
// each sent as an even then odd phase, gated by per-channel credit counters.
//
//   state | meaning
//   IDLE  | no word held, ready for a new one
//   SEND  | driving a beat phase (odd_q selects even/odd)
//   STALL | word held, waiting for every channel to have credit
module bsg_upstream_out_mc
  import bsg_upstream_out_mc_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int PHY_W       = 8,
  parameter int WORD_W      = 64,
  parameter int CREDITS     = 32,
  parameter int TOKEN_RATIO = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   core_valid_i,
  input  logic [WORD_W-1:0]                      core_data_i,
  output logic                                   core_ready_o,
  input  logic [CHANNELS-1:0]                    io_token_i,
  output logic [CHANNELS-1:0]                    io_valid_o,
  output logic [CHANNELS*PHY_W-1:0]              io_data_o,
  output logic                                   io_odd_o,
  output logic                                   commit_o,
  output logic [CHANNELS*cnt_w_f(CREDITS)-1:0]   credits_o,
  output logic [6:0]                             sent_cnt_o,
  output logic                                   overflow_o
);

  localparam int BEAT_W  = beat_w_f(PHY_W);
  localparam int BEATS   = beats_f(WORD_W, CHANNELS, PHY_W);
  localparam int CNT_W   = cnt_w_f(CREDITS);
  localparam int SLICE_W = CHANNELS * BEAT_W;
  localparam int BEAT_IW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_IW-1:0] LAST_BEAT = BEAT_IW'(BEATS - 1);
  localparam logic [BEAT_IW-1:0] BEAT_ONE  = BEAT_IW'(1);

  `BSG_UOMC_CHECK(g_chk_channels, (CHANNELS >= 1) && (CHANNELS <= 8))
  `BSG_UOMC_CHECK(g_chk_word, (PHY_W >= 1) && (BEATS >= 1) && ((WORD_W % SLICE_W) == 0))
  `BSG_UOMC_CHECK(g_chk_credits, is_pow2_f(CREDITS))
  `BSG_UOMC_CHECK(g_chk_ratio, is_pow2_f(TOKEN_RATIO) && (TOKEN_RATIO <= CREDITS))

  uo_state_e                 state_q, state_d;
  logic                      odd_q, odd_d;
  logic [BEAT_IW-1:0]        beat_q, beat_d;
  logic [WORD_W-1:0]         shreg_q, shreg_d;
  logic [CHANNELS*PHY_W-1:0] hold_q;
  logic [CHANNELS*PHY_W-1:0] lanes;
  logic [6:0]                sent_q;
  logic [CHANNELS-1:0]       has_credit;
  logic [CHANNELS-1:0]       ovf;
  logic                      all_credit;
  logic                      sending;
  logic                      even_emit;
  logic                      last_odd;
  logic                      ready;
  logic                      accept;

  assign all_credit = &has_credit;
  assign sending    = (state_q == SEND);
  assign even_emit  = sending && !odd_q;
  assign last_odd   = sending && odd_q && (beat_q == LAST_BEAT);
  assign ready      = !rst && ((state_q == IDLE) || last_odd);
  assign accept     = core_valid_i && ready;

  // The current beat always sits in the low SLICE_W bits of the shift register.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign lanes[c*PHY_W +: PHY_W] = odd_q ? shreg_q[c*BEAT_W + PHY_W +: PHY_W]
                                           : shreg_q[c*BEAT_W +: PHY_W];

    bsg_upstream_credit_ctr #(
      .CREDITS     (CREDITS),
      .TOKEN_RATIO (TOKEN_RATIO)
    ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .token      (io_token_i[c]),
      .dec        (even_emit),
      .credit     (credits_o[c*CNT_W +: CNT_W]),
      .has_credit (has_credit[c]),
      .overflow   (ovf[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      odd_q   <= 1'b0;
      beat_q  <= '0;
      shreg_q <= '0;
      hold_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      odd_q   <= odd_d;
      beat_q  <= beat_d;
      shreg_q <= shreg_d;
      if (sending)   hold_q <= lanes;
      if (even_emit) sent_q <= sent_q + 7'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    odd_d   = 1'b0;
    beat_d  = beat_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = core_data_i;
          beat_d  = '0;
          state_d = all_credit ? SEND : STALL;
        end
      end
      SEND: begin
        if (!odd_q) begin
          odd_d = 1'b1;
        end else if (beat_q != LAST_BEAT) begin
          shreg_d = shreg_q >> SLICE_W;
          beat_d  = beat_q + BEAT_ONE;
          state_d = all_credit ? SEND : STALL;
        end else if (accept) begin
          shreg_d = core_data_i;
          beat_d  = '0;
          state_d = all_credit ? SEND : STALL;
        end else begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (all_credit) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_ready_o = ready;
    io_valid_o   = {CHANNELS{sending}};
    io_data_o    = sending ? lanes : hold_q;
    io_odd_o     = odd_q;
    commit_o     = last_odd;
    sent_cnt_o   = sent_q;
    overflow_o   = |ovf;
  end

endmodule

// File: tb/tb_bsg_upstream_out_mc.sv
// Directed bench for bsg_upstream_out_mc: default 2-channel instance plus a 4-channel, 4-bit-lane instance.
module tb_bsg_upstream_out_mc;

  localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W2 = 64'h1122334455667788;
  localparam logic [63:0] W3 = 64'hA0B1C2D3E4F50617;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, core_valid, core_ready, io_odd, commit, overflow;
  logic [63:0] core_data;
  logic [1:0]  token, io_valid;
  logic [15:0] io_data;
  logic [11:0] credits;
  logic [6:0]  sent;

  logic        rst4, core_valid4, core_ready4, io_odd4, commit4, overflow4;
  logic [63:0] core_data4;
  logic [3:0]  token4, io_valid4;
  logic [15:0] io_data4;
  logic [23:0] credits4;
  logic [6:0]  sent4;

  bsg_upstream_out_mc dut (
    .clk(clk), .rst(rst), .core_valid_i(core_valid), .core_data_i(core_data),
    .core_ready_o(core_ready), .io_token_i(token), .io_valid_o(io_valid),
    .io_data_o(io_data), .io_odd_o(io_odd), .commit_o(commit), .credits_o(credits),
    .sent_cnt_o(sent), .overflow_o(overflow)
  );

  bsg_upstream_out_mc #(.CHANNELS(4), .PHY_W(4), .WORD_W(64)) dut4 (
    .clk(clk), .rst(rst4), .core_valid_i(core_valid4), .core_data_i(core_data4),
    .core_ready_o(core_ready4), .io_token_i(token4), .io_valid_o(io_valid4),
    .io_data_o(io_data4), .io_odd_o(io_odd4), .commit_o(commit4), .credits_o(credits4),
    .sent_cnt_o(sent4), .overflow_o(overflow4)
  );

  int tests = 0;
  int fails = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] exp_data, input logic exp_odd,
                          input logic exp_commit);
    chk({tag, "_valid"}, 64'(io_valid), 64'h3);
    chk({tag, "_data"}, 64'(io_data), 64'(exp_data));
    chk({tag, "_odd"}, 64'(io_odd), 64'(exp_odd));
    chk({tag, "_commit"}, 64'(commit), 64'(exp_commit));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] e1 [4];
    logic [15:0] e2 [8];
    logic [15:0] e4 [4];
    int nvalid, ncommit;
    e1 = '{16'hABEF, 16'h89CD, 16'h2367, 16'h0145};
    e2 = '{16'h6688, 16'h5577, 16'h2244, 16'h1133,
           16'hF517, 16'hE406, 16'hB1D3, 16'hA0C2};
    e4 = '{16'h9BDF, 16'h8ACE, 16'h1357, 16'h0246};

    rst = 1'b1; core_valid = 1'b0; core_data = '0; token = '0;
    rst4 = 1'b1; core_valid4 = 1'b0; core_data4 = '0; token4 = '0;
    cyc(); cyc();
    chk("rst_ready", 64'(core_ready), 64'h0);
    chk("rst_valid", 64'(io_valid), 64'h0);
    chk("rst_data", 64'(io_data), 64'h0);
    chk("rst_odd", 64'(io_odd), 64'h0);
    chk("rst_commit", 64'(commit), 64'h0);
    chk("rst_credits", 64'(credits), 64'({6'd32, 6'd32}));
    chk("rst_sent", 64'(sent), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'h0);
    rst = 1'b0; rst4 = 1'b0;
    #1;
    chk("idle_ready", 64'(core_ready), 64'h1);

    // single word on both instances
    core_valid = 1'b1; core_data = W1;
    core_valid4 = 1'b1; core_data4 = W1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      core_valid = 1'b0; core_valid4 = 1'b0;
      chk_beat("w1", e1[i], 1'(i % 2), 1'(i == 3));
      chk("w1_ready", 64'(core_ready), 64'(i == 3));
      chk("w4_valid", 64'(io_valid4), 64'hF);
      chk("w4_data", 64'(io_data4), 64'(e4[i]));
      chk("w4_commit", 64'(commit4), 64'(i == 3));
    end
    cyc();
    chk("w1_idle_valid", 64'(io_valid), 64'h0);
    chk("w1_hold_data", 64'(io_data), 64'h0145);
    chk("w1_credits", 64'(credits), 64'({6'd30, 6'd30}));
    chk("w1_sent", 64'(sent), 64'd2);
    chk("w4_credits", 64'(credits4), 64'({6'd30, 6'd30, 6'd30, 6'd30}));
    chk("w4_idle_valid", 64'(io_valid4), 64'h0);

    // back-to-back words, no bubble
    core_valid = 1'b1; core_data = W2;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) core_data = W3;
      if (i == 4) core_valid = 1'b0;
      chk_beat("b2b", e2[i], 1'(i % 2), 1'(i == 3 || i == 7));
      chk("b2b_ready", 64'(core_ready), 64'(i == 3 || i == 7));
    end
    cyc();
    chk("b2b_idle_valid", 64'(io_valid), 64'h0);
    chk("b2b_credits", 64'(credits), 64'({6'd26, 6'd26}));
    chk("b2b_sent", 64'(sent), 64'd6);

    // drain credits from full: 16 words use all 32, the 17th stalls
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    core_valid = 1'b1; core_data = W1;
    nvalid = 0; ncommit = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (io_valid == 2'b11) nvalid++;
      if (commit) ncommit++;
    end
    chk("drain_valid_cycles", 64'(nvalid), 64'd64);
    chk("drain_commits", 64'(ncommit), 64'd16);
    cyc();
    core_valid = 1'b0;
    chk("stall_valid", 64'(io_valid), 64'h0);
    chk("stall_ready", 64'(core_ready), 64'h0);
    chk("stall_credits", 64'(credits), 64'h0);
    chk("stall_sent", 64'(sent), 64'd32);
    cyc(); cyc();
    chk("stall_hold", 64'(io_valid), 64'h0);
    token[1] = 1'b1;
    cyc();
    chk("tok1_credits", 64'(credits), 64'({6'd8, 6'd0}));
    chk("tok1_valid", 64'(io_valid), 64'h0);
    cyc();
    chk("tok1_still_stalled", 64'(io_valid), 64'h0);
    token[0] = 1'b1;
    cyc();
    chk_beat("resume0", 16'hABEF, 1'b0, 1'b0);
    chk("resume_credits", 64'(credits), 64'({6'd8, 6'd8}));
    cyc();
    chk_beat("resume1", 16'h89CD, 1'b1, 1'b0);
    chk("resume_credits7", 64'(credits), 64'({6'd7, 6'd7}));
    cyc();
    chk_beat("resume2", 16'h2367, 1'b0, 1'b0);
    cyc();
    chk_beat("resume3", 16'h0145, 1'b1, 1'b1);
    cyc();
    chk("resume_idle", 64'(io_valid), 64'h0);
    chk("resume_credits6", 64'(credits), 64'({6'd6, 6'd6}));

    // token on the same cycle as an even phase, credit 5
    core_valid = 1'b1; core_data = W2;
    cyc();
    core_valid = 1'b0;
    cyc();
    chk("net_pre_credits", 64'(credits), 64'({6'd5, 6'd5}));
    cyc();
    chk("net_even", 64'(io_odd), 64'h0);
    token[0] = 1'b0;
    cyc();
    chk("net_credits", 64'(credits), 64'({6'd4, 6'd12}));
    chk("net_commit", 64'(commit), 64'h1);
    cyc();

    // token at full credit saturates and sets the sticky overflow
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    token[1] = 1'b0;
    cyc();
    chk("ovf_credits", 64'(credits), 64'({6'd32, 6'd32}));
    chk("ovf_flag", 64'(overflow), 64'h1);
    cyc(); cyc();
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // reset on the odd phase of beat 0 discards the word
    core_valid = 1'b1; core_data = W1;
    cyc();
    core_valid = 1'b0;
    cyc();
    chk("mid_odd", 64'(io_odd), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(core_ready), 64'h0);
    cyc();
    chk("mid_valid", 64'(io_valid), 64'h0);
    chk("mid_commit", 64'(commit), 64'h0);
    chk("mid_credits", 64'(credits), 64'({6'd32, 6'd32}));
    chk("mid_ovf_cleared", 64'(overflow), 64'h0);
    chk("mid_sent", 64'(sent), 64'h0);
    rst = 1'b0;
    #1;
    chk("mid_ready", 64'(core_ready), 64'h1);
    core_valid = 1'b1; core_data = W2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      core_valid = 1'b0;
      chk_beat("fresh", e2[i], 1'(i % 2), 1'(i == 3));
    end
    cyc();
    chk("fresh_idle", 64'(io_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
